// File: rtl/axilite_master.sv
// AXI4-Lite master: turns single-cycle write/read request pulses into one
// outstanding AXI4-Lite transaction at a time, with a per-transaction timeout.
module axilite_master #(
    parameter int AXI_ADDRESS_WIDTH = 16,
    parameter int TIMEOUT_CYCLES    = 64
) (
    input  logic                         AXI_ACLK,
    input  logic                         AXI_RESET,
    input  logic                         usr_wreq,
    input  logic [AXI_ADDRESS_WIDTH-3:0] usr_waddr,
    input  logic [31:0]                  usr_wdata,
    input  logic [3:0]                   usr_wstrb,
    output logic                         usr_wack,
    input  logic                         usr_rreq,
    input  logic [AXI_ADDRESS_WIDTH-3:0] usr_raddr,
    output logic [31:0]                  usr_rdata,
    output logic                         usr_rack,
    output logic [1:0]                   usr_resp,
    output logic                         usr_timeout,
    output logic                         usr_busy,
    output logic                         AXI_AWVALID,
    output logic [AXI_ADDRESS_WIDTH-1:0] AXI_AWADDR,
    input  logic                         AXI_AWREADY,
    output logic                         AXI_WVALID,
    output logic [31:0]                  AXI_WDATA,
    output logic [3:0]                   AXI_WSTRB,
    input  logic                         AXI_WREADY,
    input  logic                         AXI_BVALID,
    input  logic [1:0]                   AXI_BRESP,
    output logic                         AXI_BREADY,
    output logic                         AXI_ARVALID,
    output logic [AXI_ADDRESS_WIDTH-1:0] AXI_ARADDR,
    input  logic                         AXI_ARREADY,
    input  logic                         AXI_RVALID,
    input  logic [1:0]                   AXI_RRESP,
    input  logic [31:0]                  AXI_RDATA,
    output logic                         AXI_RREADY
);

    localparam int         UAW     = AXI_ADDRESS_WIDTH - 2;
    localparam logic [9:0] TO_LAST = 10'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R} state_t;

    state_t                         state_q, state_d;
    logic [9:0]                     cnt_q, cnt_d;
    logic                           pw_q, pw_d, pr_q, pr_d;
    logic [UAW-1:0]                 pw_addr_q, pw_addr_d, pr_addr_q, pr_addr_d;
    logic [31:0]                    pw_data_q, pw_data_d;
    logic [3:0]                     pw_strb_q, pw_strb_d;
    logic                           awvalid_q, awvalid_d, wvalid_q, wvalid_d;
    logic                           bready_q, bready_d, arvalid_q, arvalid_d, rready_q, rready_d;
    logic [AXI_ADDRESS_WIDTH-1:0]   awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [31:0]                    wdata_q, wdata_d, rdata_q, rdata_d;
    logic [3:0]                     wstrb_q, wstrb_d;
    logic                           wack_q, wack_d, rack_q, rack_d, timeout_q, timeout_d;
    logic                           busy_q, busy_d;
    logic [1:0]                     resp_q, resp_d;
    logic                           to_hit_s, wr_abort_s, rd_abort_s;

    assign to_hit_s = (cnt_q == TO_LAST);

    // Next-state, request capture and registered-output computation
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 10'd1;
        pw_d       = pw_q;
        pw_addr_d  = pw_addr_q;
        pw_data_d  = pw_data_q;
        pw_strb_d  = pw_strb_q;
        pr_d       = pr_q;
        pr_addr_d  = pr_addr_q;
        awvalid_d  = awvalid_q;
        awaddr_d   = awaddr_q;
        wvalid_d   = wvalid_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bready_d   = bready_q;
        arvalid_d  = arvalid_q;
        araddr_d   = araddr_q;
        rready_d   = rready_q;
        rdata_d    = rdata_q;
        resp_d     = resp_q;
        wack_d     = 1'b0;
        rack_d     = 1'b0;
        timeout_d  = 1'b0;
        wr_abort_s = 1'b0;
        rd_abort_s = 1'b0;

        // a request is only taken when its own slot is free; otherwise dropped
        if (usr_wreq && !pw_q) begin
            pw_d      = 1'b1;
            pw_addr_d = usr_waddr;
            pw_data_d = usr_wdata;
            pw_strb_d = usr_wstrb;
        end else begin
            pw_d = pw_d;
        end
        if (usr_rreq && !pr_q) begin
            pr_d      = 1'b1;
            pr_addr_d = usr_raddr;
        end else begin
            pr_d = pr_d;
        end

        case (state_q)
            IDLE: begin
                cnt_d = 10'd0;
                if (pw_q || usr_wreq) begin
                    state_d   = WR_AW_W;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    pw_d      = 1'b0;
                    if (pw_q) begin
                        awaddr_d = {pw_addr_q, 2'b00};
                        wdata_d  = pw_data_q;
                        wstrb_d  = pw_strb_q;
                    end else begin
                        awaddr_d = {usr_waddr, 2'b00};
                        wdata_d  = usr_wdata;
                        wstrb_d  = usr_wstrb;
                    end
                end else if (pr_q || usr_rreq) begin
                    state_d   = RD_AR;
                    arvalid_d = 1'b1;
                    pr_d      = 1'b0;
                    if (pr_q) begin
                        araddr_d = {pr_addr_q, 2'b00};
                    end else begin
                        araddr_d = {usr_raddr, 2'b00};
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WR_AW_W: begin
                if (to_hit_s) begin
                    wr_abort_s = 1'b1;
                end else begin
                    if (AXI_AWREADY) begin
                        awvalid_d = 1'b0;
                    end else begin
                        awvalid_d = awvalid_q;
                    end
                    if (AXI_WREADY) begin
                        wvalid_d = 1'b0;
                    end else begin
                        wvalid_d = wvalid_q;
                    end
                    if ((!awvalid_q || AXI_AWREADY) && (!wvalid_q || AXI_WREADY)) begin
                        state_d  = WR_B;
                        bready_d = 1'b1;
                    end else begin
                        state_d = WR_AW_W;
                    end
                end
            end
            WR_B: begin
                // a response arriving on the timeout cycle still counts as completion
                if (AXI_BVALID && bready_q) begin
                    state_d  = IDLE;
                    bready_d = 1'b0;
                    resp_d   = AXI_BRESP;
                    wack_d   = 1'b1;
                end else if (to_hit_s) begin
                    wr_abort_s = 1'b1;
                end else begin
                    state_d = WR_B;
                end
            end
            RD_AR: begin
                if (to_hit_s) begin
                    rd_abort_s = 1'b1;
                end else if (AXI_ARREADY) begin
                    state_d   = RD_R;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end else begin
                    state_d = RD_AR;
                end
            end
            RD_R: begin
                if (AXI_RVALID && rready_q) begin
                    state_d  = IDLE;
                    rready_d = 1'b0;
                    rdata_d  = AXI_RDATA;
                    resp_d   = AXI_RRESP;
                    rack_d   = 1'b1;
                end else if (to_hit_s) begin
                    rd_abort_s = 1'b1;
                end else begin
                    state_d = RD_R;
                end
            end
            default: begin
                state_d   = IDLE;
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                bready_d  = 1'b0;
                arvalid_d = 1'b0;
                rready_d  = 1'b0;
            end
        endcase

        // bus recovery: abandon the hung transaction and report SLVERR
        if (wr_abort_s || rd_abort_s) begin
            state_d   = IDLE;
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            bready_d  = 1'b0;
            arvalid_d = 1'b0;
            rready_d  = 1'b0;
            resp_d    = 2'b10;
            timeout_d = 1'b1;
            wack_d    = wr_abort_s;
            rack_d    = rd_abort_s;
            if (rd_abort_s) begin
                rdata_d = 32'hDEAD_BEEF;
            end else begin
                rdata_d = rdata_q;
            end
        end else begin
            timeout_d = 1'b0;
        end

        busy_d = pw_d | pr_d | (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
        if (AXI_RESET) begin
            state_q   <= IDLE;
            cnt_q     <= 10'd0;
            pw_q      <= 1'b0;
            pw_addr_q <= '0;
            pw_data_q <= 32'd0;
            pw_strb_q <= 4'd0;
            pr_q      <= 1'b0;
            pr_addr_q <= '0;
            awvalid_q <= 1'b0;
            awaddr_q  <= '0;
            wvalid_q  <= 1'b0;
            wdata_q   <= 32'd0;
            wstrb_q   <= 4'd0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            rready_q  <= 1'b0;
            rdata_q   <= 32'd0;
            resp_q    <= 2'b00;
            wack_q    <= 1'b0;
            rack_q    <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pw_q      <= pw_d;
            pw_addr_q <= pw_addr_d;
            pw_data_q <= pw_data_d;
            pw_strb_q <= pw_strb_d;
            pr_q      <= pr_d;
            pr_addr_q <= pr_addr_d;
            awvalid_q <= awvalid_d;
            awaddr_q  <= awaddr_d;
            wvalid_q  <= wvalid_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            araddr_q  <= araddr_d;
            rready_q  <= rready_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            wack_q    <= wack_d;
            rack_q    <= rack_d;
            timeout_q <= timeout_d;
            busy_q    <= busy_d;
        end
    end

    assign AXI_AWVALID = awvalid_q;
    assign AXI_AWADDR  = awaddr_q;
    assign AXI_WVALID  = wvalid_q;
    assign AXI_WDATA   = wdata_q;
    assign AXI_WSTRB   = wstrb_q;
    assign AXI_BREADY  = bready_q;
    assign AXI_ARVALID = arvalid_q;
    assign AXI_ARADDR  = araddr_q;
    assign AXI_RREADY  = rready_q;
    assign usr_wack    = wack_q;
    assign usr_rack    = rack_q;
    assign usr_rdata   = rdata_q;
    assign usr_resp    = resp_q;
    assign usr_timeout = timeout_q;
    assign usr_busy    = busy_q;

endmodule

// File: tb/tb_axilite_master.sv
// Randomized bench for axilite_master: a delay-programmable slave plus a
// transaction-level latency/response model derived from the protocol rules.
module tb_axilite_master;

    localparam int TO    = 64;
    localparam int BOUND = 300;

    logic        AXI_ACLK = 1'b0;
    logic        AXI_RESET = 1'b1;
    logic        usr_wreq = 1'b0, usr_rreq = 1'b0;
    logic [13:0] usr_waddr = 14'd0, usr_raddr = 14'd0;
    logic [31:0] usr_wdata = 32'd0;
    logic [3:0]  usr_wstrb = 4'd0;
    logic        usr_wack, usr_rack, usr_timeout, usr_busy;
    logic [31:0] usr_rdata;
    logic [1:0]  usr_resp;
    logic        AXI_AWVALID, AXI_WVALID, AXI_BREADY, AXI_ARVALID, AXI_RREADY;
    logic [15:0] AXI_AWADDR, AXI_ARADDR;
    logic [31:0] AXI_WDATA;
    logic [3:0]  AXI_WSTRB;
    logic        AXI_AWREADY = 1'b0, AXI_WREADY = 1'b0, AXI_BVALID = 1'b0;
    logic        AXI_ARREADY = 1'b0, AXI_RVALID = 1'b0;
    logic [1:0]  AXI_BRESP = 2'b00, AXI_RRESP = 2'b00;
    logic [31:0] AXI_RDATA = 32'd0;

    axilite_master #(.AXI_ADDRESS_WIDTH(16), .TIMEOUT_CYCLES(TO)) dut (
        .AXI_ACLK(AXI_ACLK), .AXI_RESET(AXI_RESET),
        .usr_wreq(usr_wreq), .usr_waddr(usr_waddr), .usr_wdata(usr_wdata), .usr_wstrb(usr_wstrb),
        .usr_wack(usr_wack), .usr_rreq(usr_rreq), .usr_raddr(usr_raddr), .usr_rdata(usr_rdata),
        .usr_rack(usr_rack), .usr_resp(usr_resp), .usr_timeout(usr_timeout), .usr_busy(usr_busy),
        .AXI_AWVALID(AXI_AWVALID), .AXI_AWADDR(AXI_AWADDR), .AXI_AWREADY(AXI_AWREADY),
        .AXI_WVALID(AXI_WVALID), .AXI_WDATA(AXI_WDATA), .AXI_WSTRB(AXI_WSTRB), .AXI_WREADY(AXI_WREADY),
        .AXI_BVALID(AXI_BVALID), .AXI_BRESP(AXI_BRESP), .AXI_BREADY(AXI_BREADY),
        .AXI_ARVALID(AXI_ARVALID), .AXI_ARADDR(AXI_ARADDR), .AXI_ARREADY(AXI_ARREADY),
        .AXI_RVALID(AXI_RVALID), .AXI_RRESP(AXI_RRESP), .AXI_RDATA(AXI_RDATA), .AXI_RREADY(AXI_RREADY)
    );

    always #5 AXI_ACLK = ~AXI_ACLK;

    int checks = 0, failures = 0, cyc = 0;
    // slave plan: ready/valid delays in cycles, returned data and responses
    int tw_da, tw_dw, tw_db, tr_da, tr_dr;
    logic [13:0] tw_addr, tr_addr;
    logic [31:0] tw_data, tr_rdata;
    logic [3:0]  tw_strb;
    logic [1:0]  tw_bresp, tr_rresp;
    int aw_wait, w_wait, b_wait, ar_wait, r_wait;
    int aw_cnt, aw_first, w_cnt, ar_cnt, ar_first, wack_cnt, wack_cyc, rack_cnt, rack_cyc, to_cnt, to_paired;
    logic [15:0] awaddr_seen, araddr_seen;
    logic [31:0] wdata_seen, rdata_rack;
    logic [3:0]  wstrb_seen;
    logic [1:0]  resp_wack, resp_rack;
    logic        busy_wack, busy_rack, aw_unstable, w_unstable, ar_unstable;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic clr_mon();
        cyc = 0; aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        aw_cnt = 0; aw_first = 0; w_cnt = 0; ar_cnt = 0; ar_first = 0;
        wack_cnt = 0; wack_cyc = 0; rack_cnt = 0; rack_cyc = 0; to_cnt = 0; to_paired = 0;
        aw_unstable = 1'b0; w_unstable = 1'b0; ar_unstable = 1'b0;
    endtask

    // one clock: observe DUT outputs after the edge, then drive the slave side
    task automatic tick();
        @(posedge AXI_ACLK);
        #1;
        cyc++;
        if (AXI_AWVALID) begin
            if (aw_cnt == 0) begin aw_first = cyc; awaddr_seen = AXI_AWADDR; end
            else if (AXI_AWADDR !== awaddr_seen) aw_unstable = 1'b1;
            aw_cnt++;
        end
        if (AXI_WVALID) begin
            if (w_cnt == 0) begin wdata_seen = AXI_WDATA; wstrb_seen = AXI_WSTRB; end
            else if (AXI_WDATA !== wdata_seen || AXI_WSTRB !== wstrb_seen) w_unstable = 1'b1;
            w_cnt++;
        end
        if (AXI_ARVALID) begin
            if (ar_cnt == 0) begin ar_first = cyc; araddr_seen = AXI_ARADDR; end
            else if (AXI_ARADDR !== araddr_seen) ar_unstable = 1'b1;
            ar_cnt++;
        end
        if (usr_wack) begin wack_cnt++; wack_cyc = cyc; resp_wack = usr_resp; busy_wack = usr_busy; end
        if (usr_rack) begin
            rack_cnt++; rack_cyc = cyc; resp_rack = usr_resp; busy_rack = usr_busy; rdata_rack = usr_rdata;
        end
        if (usr_timeout) begin to_cnt++; if (usr_wack || usr_rack) to_paired++; end
        if (AXI_AWVALID) begin AXI_AWREADY = (aw_wait >= tw_da); aw_wait++; end else AXI_AWREADY = 1'b0;
        if (AXI_WVALID)  begin AXI_WREADY  = (w_wait >= tw_dw);  w_wait++;  end else AXI_WREADY  = 1'b0;
        if (AXI_BREADY)  begin AXI_BVALID  = (b_wait >= tw_db);  b_wait++;  end else AXI_BVALID  = 1'b0;
        if (AXI_ARVALID) begin AXI_ARREADY = (ar_wait >= tr_da); ar_wait++; end else AXI_ARREADY = 1'b0;
        if (AXI_RREADY)  begin AXI_RVALID  = (r_wait >= tr_dr);  r_wait++;  end else AXI_RVALID  = 1'b0;
        AXI_BRESP = tw_bresp;
        AXI_RRESP = tr_rresp;
        AXI_RDATA = AXI_RVALID ? tr_rdata : 32'h0;
    endtask

    // issue a write, a read, or both in one cycle, then compare with the model
    task automatic run_txn(input bit do_w, input bit do_r);
        int nw, w_done, nr, s, r_done;
        bit wto, rto;
        check_val("idle_before", {31'd0, usr_busy}, 32'd0);
        clr_mon();
        if (do_w) begin usr_wreq = 1'b1; usr_waddr = tw_addr; usr_wdata = tw_data; usr_wstrb = tw_strb; end
        if (do_r) begin usr_rreq = 1'b1; usr_raddr = tr_addr; end
        tick();
        usr_wreq = 1'b0; usr_rreq = 1'b0;
        usr_waddr = ~tw_addr; usr_wdata = ~tw_data; usr_wstrb = ~tw_strb; usr_raddr = ~tr_addr;
        if (do_w && do_r) begin
            // second read while one is already pending must be dropped
            usr_rreq = 1'b1; usr_raddr = tr_addr ^ 14'h1;
            tick();
            usr_rreq = 1'b0;
        end
        while (!((!do_w || wack_cnt > 0) && (!do_r || rack_cnt > 0)) && cyc < BOUND) tick();
        check_val("done_in_bound", {31'd0, cyc < BOUND}, 32'd1);
        repeat (3) tick();
        w_done = 0;
        if (do_w) begin
            nw = 2 + imax(tw_da, tw_dw) + tw_db;
            wto = (nw > TO);
            w_done = wto ? TO + 1 : nw + 1;
            check_val("aw_first", aw_first, 1);
            check_val("awaddr", {16'd0, awaddr_seen}, {16'd0, tw_addr, 2'b00});
            check_val("aw_cycles", aw_cnt, imin(tw_da + 1, TO));
            check_val("w_cycles", w_cnt, imin(tw_dw + 1, TO));
            check_val("wdata", wdata_seen, tw_data);
            check_val("wstrb", {28'd0, wstrb_seen}, {28'd0, tw_strb});
            check_val("aw_w_stable", {30'd0, aw_unstable, w_unstable}, 32'd0);
            check_val("wack_count", wack_cnt, 1);
            check_val("wack_cycle", wack_cyc, w_done);
            check_val("wresp", {30'd0, resp_wack}, wto ? 32'd2 : {30'd0, tw_bresp});
            check_val("busy_at_wack", {31'd0, busy_wack}, {31'd0, do_r});
        end else begin
            wto = 1'b0;
            check_val("no_aw", aw_cnt, 0);
        end
        if (do_r) begin
            s = do_w ? w_done : 0;
            nr = 2 + tr_da + tr_dr;
            rto = (nr > TO);
            r_done = s + (rto ? TO + 1 : nr + 1);
            check_val("ar_first", ar_first, s + 1);
            check_val("araddr", {16'd0, araddr_seen}, {16'd0, tr_addr, 2'b00});
            check_val("ar_cycles", ar_cnt, imin(tr_da + 1, TO));
            check_val("ar_stable", {31'd0, ar_unstable}, 32'd0);
            check_val("rack_count", rack_cnt, 1);
            check_val("rack_cycle", rack_cyc, r_done);
            check_val("rresp", {30'd0, resp_rack}, rto ? 32'd2 : {30'd0, tr_rresp});
            check_val("rdata", rdata_rack, rto ? 32'hDEAD_BEEF : tr_rdata);
            check_val("rdata_held", usr_rdata, rto ? 32'hDEAD_BEEF : tr_rdata);
            check_val("busy_at_rack", {31'd0, busy_rack}, 32'd0);
        end else begin
            rto = 1'b0;
            check_val("no_ar", ar_cnt, 0);
        end
        check_val("timeout_count", to_cnt, int'(wto) + int'(rto));
        check_val("timeout_paired", to_paired, int'(wto) + int'(rto));
        tick();
    endtask

    function automatic int rnd_delay();
        return ($urandom_range(0, 9) == 0) ? int'($urandom_range(55, 70)) : int'($urandom_range(0, 3));
    endfunction

    initial begin
        tw_da = 0; tw_dw = 0; tw_db = 0; tr_da = 0; tr_dr = 0;
        tw_addr = 14'd0; tr_addr = 14'd0; tw_data = 32'd0; tr_rdata = 32'd0;
        tw_strb = 4'd0; tw_bresp = 2'b00; tr_rresp = 2'b00;
        clr_mon();
        repeat (3) @(posedge AXI_ACLK);
        #1;
        check_val("rst_axi_ctl", {27'd0, AXI_AWVALID, AXI_WVALID, AXI_BREADY, AXI_ARVALID, AXI_RREADY}, 32'd0);
        check_val("rst_addr", {AXI_AWADDR, AXI_ARADDR}, 32'd0);
        check_val("rst_wdata", AXI_WDATA, 32'd0);
        check_val("rst_usr_ctl", {26'd0, AXI_WSTRB, usr_wack, usr_rack}, 32'd0);
        check_val("rst_usr_flags", {28'd0, usr_resp, usr_timeout, usr_busy}, 32'd0);
        check_val("rst_rdata", usr_rdata, 32'd0);
        AXI_RESET = 1'b0;
        tick();

        // directed: zero-wait write
        tw_addr = 14'h0003; tw_data = 32'h1234_5678; tw_strb = 4'hF; tw_bresp = 2'b00;
        tw_da = 0; tw_dw = 0; tw_db = 0;
        run_txn(1'b1, 1'b0);
        // directed: read with two RVALID wait cycles
        tr_addr = 14'h0002; tr_rdata = 32'hCAFE_F00D; tr_rresp = 2'b00; tr_da = 0; tr_dr = 2;
        run_txn(1'b0, 1'b1);
        // directed: AWREADY four cycles late
        tw_addr = 14'h0155; tw_data = 32'hA5A5_0F0F; tw_strb = 4'h5; tw_da = 4; tw_dw = 0; tw_db = 1;
        run_txn(1'b1, 1'b0);
        // directed: simultaneous write and read, read returns DECERR
        tw_da = 0; tw_dw = 0; tw_db = 0; tw_addr = 14'h0010; tw_data = 32'h0BAD_F00D; tw_strb = 4'hC;
        tr_addr = 14'h0100; tr_rdata = 32'h7654_3210; tr_rresp = 2'b11; tr_da = 0; tr_dr = 0;
        run_txn(1'b1, 1'b1);
        // directed: slave never accepts the address
        tw_da = 1000; tw_dw = 0; tw_db = 0; tw_addr = 14'h0777;
        run_txn(1'b1, 1'b0);
        check_val("busy_after_timeout", {31'd0, usr_busy}, 32'd0);

        // directed: asynchronous reset while waiting in the R phase with a write pending
        tr_addr = 14'h0055; tr_da = 0; tr_dr = 20; tr_rresp = 2'b00; tr_rdata = 32'h1111_2222;
        tw_da = 0; tw_dw = 0; tw_db = 0;
        clr_mon();
        usr_rreq = 1'b1; usr_raddr = tr_addr;
        tick();
        usr_rreq = 1'b0;
        tick();
        check_val("rst_pre_rready", {31'd0, AXI_RREADY}, 32'd1);
        usr_wreq = 1'b1; usr_waddr = 14'h0033; usr_wdata = 32'h5555_AAAA; usr_wstrb = 4'hF;
        tick();
        usr_wreq = 1'b0;
        check_val("rst_pre_busy", {31'd0, usr_busy}, 32'd1);
        #3;
        AXI_RESET = 1'b1;
        #1;
        check_val("rst_async_rready", {31'd0, AXI_RREADY}, 32'd0);
        check_val("rst_async_busy", {31'd0, usr_busy}, 32'd0);
        tick();
        tick();
        AXI_RESET = 1'b0;
        clr_mon();
        repeat (5) tick();
        check_val("rst_no_aw", aw_cnt, 0);
        check_val("rst_no_ack", wack_cnt + rack_cnt, 0);
        check_val("rst_idle_busy", {31'd0, usr_busy}, 32'd0);
        tr_dr = 1; tr_rdata = 32'h3333_4444;
        run_txn(1'b0, 1'b1);

        // randomized transactions
        for (int i = 0; i < 40; i++) begin
            int mode;
            mode = int'($urandom_range(0, 2));
            tw_addr = 14'($urandom); tw_data = $urandom; tw_strb = 4'($urandom); tw_bresp = 2'($urandom);
            tw_da = rnd_delay(); tw_dw = rnd_delay(); tw_db = rnd_delay();
            tr_addr = 14'($urandom); tr_rdata = $urandom; tr_rresp = 2'($urandom);
            tr_da = rnd_delay(); tr_dr = rnd_delay();
            run_txn(mode != 1, mode != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
